// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches over req/ack and queues
// {pc, instr} pairs for IF_ID; a redirect flushes the queue and refetches.
module if_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  output logic [1:0]  state_o
);

  // Handshakes: imem transfer when imem_req_o && imem_ack_i (req/addr never drop
  // before ack); IF_ID transfer when instr_valid_o && instr_ready_i.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [31:0]        fetch_pc_q, fetch_pc_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
  logic [31:0]        mem_pc    [DEPTH];
  logic [31:0]        mem_instr [DEPTH];
  logic               ack_fire, push, pop, hold, can_issue, head_bypass;
  logic               req_n, valid_n;
  logic [31:0]        addr_n, head_pc_n, head_instr_n, redirect_pc_aligned;

  assign state_o             = state_q;
  assign redirect_pc_aligned = redirect_pc_i & ~32'h3;
  assign ack_fire            = imem_req_o && imem_ack_i;
  assign hold                = imem_req_o && !imem_ack_i;
  // Only a REQ response is kept; redirect kills both the push and the pop.
  assign push                = ack_fire && (state_q == REQ) && !redirect_i;
  assign pop                 = instr_valid_o && instr_ready_i && !redirect_i;

  always_comb begin
    count_n  = count_q;
    rd_ptr_n = rd_ptr_q;
    wr_ptr_n = wr_ptr_q;
    if (redirect_i) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end else begin
      count_n  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_n = rd_ptr_q + PTR_W'(pop);
      wr_ptr_n = wr_ptr_q + PTR_W'(push);
    end
  end

  // Credit uses the post-update count; the new request becomes the outstanding one.
  assign can_issue = start_i && (count_n < CNT_W'(DEPTH));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (can_issue) state_n = REQ;
      REQ: begin
        if (ack_fire)        state_n = can_issue ? REQ : IDLE;
        else if (redirect_i) state_n = DRAIN;
      end
      DRAIN:   if (ack_fire) state_n = can_issue ? REQ : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_n = fetch_pc_q;
    if (redirect_i)  fetch_pc_n = redirect_pc_aligned;
    else if (push)   fetch_pc_n = fetch_pc_q + 32'd4;
    req_n  = hold ? 1'b1 : (state_n == REQ);
    addr_n = imem_addr_o;
    if (!hold && state_n == REQ) addr_n = fetch_pc_n;
    // A push into the slot that becomes the head must bypass the memory array.
    head_bypass  = push && (wr_ptr_q == rd_ptr_n);
    head_pc_n    = head_bypass ? fetch_pc_q  : mem_pc[rd_ptr_n];
    head_instr_n = head_bypass ? imem_data_i : mem_instr[rd_ptr_n];
    valid_n      = (count_n != '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= RESET_PC;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      pc_o          <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_n;
      count_q       <= count_n;
      rd_ptr_q      <= rd_ptr_n;
      wr_ptr_q      <= wr_ptr_n;
      imem_req_o    <= req_n;
      imem_addr_o   <= addr_n;
      instr_valid_o <= valid_n;
      if (valid_n) begin
        instr_o <= head_instr_n;
        pc_o    <= head_pc_n;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_ptr_q]    <= fetch_pc_q;
      mem_instr[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: memory responder plus queue-based reference model
// checked every cycle, directed corner sequences and a redirect alignment table.
module tb_if_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0, redirect_i = 1'b0, ready_i = 1'b0;
  logic [31:0] rpc_i = '0;
  logic        ack_i, req_o, valid_o;
  logic [31:0] data_i, addr_o, instr_o, pc_o;
  logic [1:0]  state_o;

  logic        start_w = 1'b0, ack_w = 1'b0, ready_w = 1'b0, redirect_w = 1'b0;
  logic [31:0] data_w = '0, rpc_w = '0;
  logic        req_w, valid_w;
  logic [31:0] addr_w, instr_w, pc_w;
  logic [1:0]  state_w;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] head_e;
  logic [31:0] m_addr;
  logic        m_drain, fire, mem_en;
  int          fire_cnt = 0, wait_cnt = 0, ack_delay = 1;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } redir_vec_t;
  redir_vec_t vecs [5];

  if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .redirect_i(redirect_i),
    .redirect_pc_i(rpc_i), .imem_req_o(req_o), .imem_addr_o(addr_o),
    .imem_ack_i(ack_i), .imem_data_i(data_i), .instr_valid_o(valid_o),
    .instr_o(instr_o), .pc_o(pc_o), .instr_ready_i(ready_i), .state_o(state_o)
  );

  if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_w), .redirect_i(redirect_w),
    .redirect_pc_i(rpc_w), .imem_req_o(req_w), .imem_addr_o(addr_w),
    .imem_ack_i(ack_w), .imem_data_i(data_w), .instr_valid_o(valid_w),
    .instr_o(instr_w), .pc_o(pc_w), .instr_ready_i(ready_w), .state_o(state_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req_o && addr_o == a) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
    check(name, found, 1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Memory responder and scoreboard; inputs seen here are those the next edge samples.
  initial begin
    ack_i  = 1'b0;
    data_i = '0;
    mem_en = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_i    = 1'b0;
        wait_cnt = 0;
        exp_q.delete();
        m_addr   = 32'h0;
        m_drain  = 1'b0;
      end else begin
        if (req_o && mem_en && wait_cnt >= ack_delay) begin
          ack_i    = 1'b1;
          data_i   = addr_o ^ K;
          wait_cnt = 0;
        end else begin
          ack_i = 1'b0;
          if (req_o && mem_en) wait_cnt++;
          else                 wait_cnt = 0;
        end
        fire = req_o && ack_i;
        check("head_valid", valid_o, exp_q.size() != 0);
        if (valid_o && exp_q.size() != 0) begin
          head_e = exp_q[0];
          check("head_pc", pc_o, head_e[63:32]);
          check("head_instr", instr_o, head_e[31:0]);
        end
        if (fire) fire_cnt++;
        if (redirect_i) begin
          exp_q.delete();
          m_addr  = rpc_i & ~32'h3;
          m_drain = req_o && !fire;
        end else begin
          if (valid_o && ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
          if (fire) begin
            if (m_drain) m_drain = 1'b0;
            else begin
              check("fetch_addr", addr_o, m_addr);
              exp_q.push_back({m_addr, m_addr ^ K});
              m_addr = m_addr + 32'd4;
            end
          end
        end
      end
    end
  end

  initial begin
    logic        found;
    int          f0;
    logic [31:0] exp_w [3];
    vecs[0] = '{32'h0000_0203, 32'h0000_0200};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0003, 32'h0000_0000};
    vecs[4] = '{32'h8000_0006, 32'h8000_0004};
    exp_w[0] = 32'hFFFF_FFF8;
    exp_w[1] = 32'hFFFF_FFFC;
    exp_w[2] = 32'h0000_0000;

    #1 rst_n = 1'b0;
    #1;
    check("rst_req", req_o, 0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_valid", valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_addr_w", addr_w, 32'hFFFF_FFF8);
    cyc(2);
    rst_n = 1'b1;

    // Streaming with one-cycle ack latency
    start_i = 1'b1; ready_i = 1'b1; ack_delay = 1;
    wait_req(32'h0, "first_req");
    cyc(30);

    // Stall: buffer fills to DEPTH, then a single pop earns exactly one refetch
    ready_i = 1'b0;
    cyc(30);
    check("stall_fill", exp_q.size(), DEPTH);
    check("stall_req_low", req_o, 0);
    check("stall_valid", valid_o, 1);
    f0 = fire_cnt;
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    cyc(15);
    check("one_refill", fire_cnt - f0, 1);
    check("refill_full", exp_q.size(), DEPTH);
    check("refill_req_low", req_o, 0);

    // Redirect while the request to 0x8 waits for its ack
    apply_reset();
    ready_i = 1'b1;
    wait_req(32'h8, "req_0x8");
    mem_en = 1'b0;
    redirect_i = 1'b1; rpc_i = 32'h100;
    cyc(1);
    redirect_i = 1'b0;
    check("drain_req", req_o, 1);
    check("drain_addr", addr_o, 32'h8);
    check("drain_flush", valid_o, 0);
    cyc(1);
    check("drain_addr2", addr_o, 32'h8);
    cyc(1);
    mem_en = 1'b1;
    wait_req(32'h100, "after_drain_req");
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o) begin found = 1'b1; break; end
      cyc(1);
    end
    check("after_drain_valid", found, 1);
    check("after_drain_pc", pc_o, 32'h100);

    // Redirect coinciding with ack and pop
    ack_delay = 0;
    cyc(6);
    check("coinc_pre", {req_o, valid_o}, 2'b11);
    redirect_i = 1'b1; rpc_i = 32'h203;
    cyc(1);
    redirect_i = 1'b0;
    check("coinc_flush", valid_o, 0);
    check("coinc_req", req_o, 1);
    check("coinc_addr", addr_o, 32'h200);
    cyc(10);

    // Reset during REQ with two entries buffered
    ack_delay = 1; ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 2 && req_o) begin found = 1'b1; break; end
      cyc(1);
    end
    check("mid_pre", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_req", req_o, 0);
    check("mid_addr", addr_o, 32'h0);
    check("mid_valid", valid_o, 0);
    check("mid_instr", instr_o, 0);
    check("mid_pc", pc_o, 0);
    check("mid_state", state_o, 0);
    cyc(2);
    rst_n = 1'b1; ready_i = 1'b1;
    wait_req(32'h0, "restart_req");
    check("restart_no_stale", valid_o, 0);
    cyc(20);

    // Redirect alignment table, each issued from IDLE
    start_i = 1'b0;
    cyc(10);
    for (int v = 0; v < 5; v++) begin
      start_i = 1'b1; redirect_i = 1'b1; rpc_i = vecs[v].rpc;
      cyc(1);
      start_i = 1'b0; redirect_i = 1'b0;
      check("tbl_req", req_o, 1);
      check("tbl_addr", addr_o, vecs[v].exp_addr);
      cyc(8);
      check("tbl_idle", {req_o, valid_o}, 2'b00);
    end

    // PC wrap at the top of the address space
    start_w = 1'b1;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (req_w) begin found = 1'b1; break; end
        cyc(1);
      end
      check("wrap_req", found, 1);
      check("wrap_addr", addr_w, exp_w[k]);
      ack_w = 1'b1; data_w = exp_w[k] ^ K;
      if (k == 2) start_w = 1'b0;
      cyc(1);
      ack_w = 1'b0;
    end
    ready_w = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wrap_valid", valid_w, 1);
      check("wrap_pc", pc_w, exp_w[k]);
      check("wrap_instr", instr_w, exp_w[k] ^ K);
      @(posedge clk);
      #1;
    end
    ready_w = 1'b0;
    check("wrap_empty", valid_w, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
